// File: rtl/dm_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_bus_arbiter_if
// Bus bundle between the two data-memory requesters, the arbiter and the
// single-port data memory.
//   Requester k (k = 0 CPU M-stage, k = 1 DMA/loader/debug):
//     reqk, lockk, addrk, wdatak, byteenk  -> arbiter
//     gntk, rvalidk, rdatak, errk          <- arbiter
//   Memory side:
//     mem_addr, mem_wdata, mem_byteen      -> memory
//     mem_rdata                            <- memory
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memory)
// -----------------------------------------------------------------------------
interface dm_bus_arbiter_if;
    logic        req0,    req1;
    logic        lock0,   lock1;
    logic [31:0] addr0,   addr1;
    logic [31:0] wdata0,  wdata1;
    logic [3:0]  byteen0, byteen1;
    logic        gnt0,    gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata0,  rdata1;
    logic        err0,    err1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, lock0, lock1, addr0, addr1, wdata0, wdata1,
               byteen0, byteen1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_addr, mem_wdata, mem_byteen
    );

    modport master (
        output req0, req1, lock0, lock1, addr0, addr1, wdata0, wdata1,
               byteen0, byteen1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_addr, mem_wdata, mem_byteen
    );
endinterface

// File: rtl/dm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dm_bus_arbiter
// Shares one single-port data memory (combinational read, byte-enabled
// synchronous write) between the CPU data port (requester 0) and a secondary
// master (requester 1). The grant is decided combinationally every cycle and
// the granted requester's address/data/byte enables are steered to memory.
// Reads return registered data with a per-requester valid pulse one cycle
// after the grant. Short locked bursts are supported, and requester 1 is
// protected from starvation by a wait counter.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : dm_bus_arbiter_if.slave (requester and memory signals)
// Parameters:
//   DEPTH    : memory depth in 32-bit words (word index = addr >> 2)
//   MAX_WAIT : cycles requester 1 may wait before it is forced in
//   MAX_LOCK : maximum consecutive locked beats before a forced release
//   PRIO_CPU : 1 = fixed priority to requester 0, 0 = round-robin
// -----------------------------------------------------------------------------
module dm_bus_arbiter #(
    parameter int DEPTH    = 4096,
    parameter int MAX_WAIT = 8,
    parameter int MAX_LOCK = 4,
    parameter int PRIO_CPU = 1
) (
    input  logic            clk,
    input  logic            reset,
    dm_bus_arbiter_if.slave bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int LOCK_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    owner_e            lock_owner_q, lock_owner_d;
    logic [LOCK_W-1:0] lock_cnt_q,   lock_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic              rvalid0_q,    rvalid0_d;
    logic              rvalid1_q,    rvalid1_d;
    logic              err0_q,       err0_d;
    logic              err1_q,       err1_d;
    logic [31:0]       rdata0_q,     rdata0_d;
    logic [31:0]       rdata1_q,     rdata1_d;

    logic        gnt0, gnt1, granted;
    logic        oor0, oor1, read0, read1;
    logic        hold0, hold1, expired0, expired1;
    logic        wait_full;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_byteen;
    logic        sel_oor;
    logic [3:0]  mem_byteen;

    assign oor0      = (bus.addr0 >> 2) >= 32'(DEPTH);
    assign oor1      = (bus.addr1 >> 2) >= 32'(DEPTH);
    assign read0     = (bus.byteen0 == 4'b0000);
    assign read1     = (bus.byteen1 == 4'b0000);
    assign wait_full = (wait_cnt_q == WAIT_W'(MAX_WAIT));

    // A lock is honoured only while its owner keeps requesting and the burst
    // is still below MAX_LOCK beats; at MAX_LOCK it has "expired" and the
    // other requester gets exactly one arbitration in its place.
    assign hold0    = (lock_owner_q == OWN_0) && bus.req0 && (lock_cnt_q < LOCK_W'(MAX_LOCK));
    assign hold1    = (lock_owner_q == OWN_1) && bus.req1 && (lock_cnt_q < LOCK_W'(MAX_LOCK));
    assign expired0 = (lock_owner_q == OWN_0) && (lock_cnt_q == LOCK_W'(MAX_LOCK));
    assign expired1 = (lock_owner_q == OWN_1) && (lock_cnt_q == LOCK_W'(MAX_LOCK));

    // Grant decision. Gated by reset so no grant is visible while reset is
    // asserted, without waiting for a clock edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            gnt0 = 1'b0;
        end else if (hold0) begin
            gnt0 = 1'b1;
        end else if (hold1) begin
            gnt1 = 1'b1;
        end else if (bus.req0 && !bus.req1) begin
            gnt0 = 1'b1;
        end else if (bus.req1 && !bus.req0) begin
            gnt1 = 1'b1;
        end else if (bus.req0 && bus.req1) begin
            if (expired0)              gnt1 = 1'b1;
            else if (expired1)         gnt0 = 1'b1;
            else if (wait_full)        gnt1 = 1'b1;
            else if (PRIO_CPU != 0)    gnt0 = 1'b1;
            else if (last_grant_q)     gnt0 = 1'b1;
            else                       gnt1 = 1'b1;
        end
    end

    assign granted = gnt0 | gnt1;

    // Memory steering. Address and write data hold their last value when
    // nobody is granted; byte enables drop to zero so nothing is written.
    always_comb begin
        sel_addr   = gnt1 ? bus.addr1   : bus.addr0;
        sel_wdata  = gnt1 ? bus.wdata1  : bus.wdata0;
        sel_byteen = gnt1 ? bus.byteen1 : bus.byteen0;
        sel_oor    = gnt1 ? oor1        : oor0;

        mem_addr_d  = granted ? (sel_addr & 32'hFFFF_FFFC) : mem_addr_q;
        mem_wdata_d = granted ? sel_wdata : mem_wdata_q;
        mem_byteen  = (granted && !sel_oor) ? sel_byteen : 4'b0000;
    end

    // Next-state for arbitration bookkeeping and read return.
    always_comb begin
        last_grant_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_grant_q);

        if (bus.req1 && !gnt1) begin
            wait_cnt_d = wait_full ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end

        // A beat granted through hold* continues the burst; any other locked
        // grant (including the one right after a forced release) starts anew.
        lock_owner_d = OWN_NONE;
        lock_cnt_d   = '0;
        if (gnt0 && bus.lock0) begin
            lock_owner_d = OWN_0;
            lock_cnt_d   = hold0 ? lock_cnt_q + LOCK_W'(1) : LOCK_W'(1);
        end else if (gnt1 && bus.lock1) begin
            lock_owner_d = OWN_1;
            lock_cnt_d   = hold1 ? lock_cnt_q + LOCK_W'(1) : LOCK_W'(1);
        end

        rvalid0_d = gnt0 && read0;
        rvalid1_d = gnt1 && read1;
        err0_d    = gnt0 && oor0;
        err1_d    = gnt1 && oor1;
        rdata0_d  = rvalid0_d ? (oor0 ? 32'h0 : bus.mem_rdata) : rdata0_q;
        rdata1_d  = rvalid1_d ? (oor1 ? 32'h0 : bus.mem_rdata) : rdata1_q;
    end

    // NOTE: all state here is control/data-return flops, so every one of them
    // is reset; the memory array itself lives outside and is never reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_owner_q <= OWN_NONE;
            lock_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.mem_addr   = mem_addr_d;
    assign bus.mem_wdata  = mem_wdata_d;
    assign bus.mem_byteen = mem_byteen;
    assign bus.rvalid0    = rvalid0_q;
    assign bus.rvalid1    = rvalid1_q;
    assign bus.err0       = err0_q;
    assign bus.err1       = err1_q;
    assign bus.rdata0     = rdata0_q;
    assign bus.rdata1     = rdata1_q;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_bus_arbiter
// Directed bench for dm_bus_arbiter. One instance runs fixed CPU priority
// against a byte-enabled memory model; a second instance runs round-robin.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_dm_bus_arbiter;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    dm_bus_arbiter_if bus ();
    dm_bus_arbiter_if bus_rr ();

    logic [31:0] mem_model [DEPTH] = '{default: 32'h0};

    always #5 clk = ~clk;

    dm_bus_arbiter #(
        .DEPTH(DEPTH), .MAX_WAIT(8), .MAX_LOCK(4), .PRIO_CPU(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    dm_bus_arbiter #(
        .DEPTH(DEPTH), .MAX_WAIT(8), .MAX_LOCK(4), .PRIO_CPU(0)
    ) dut_rr (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_rr)
    );

    // Memory model: combinational read (out-of-range reads return a poison
    // value the arbiter must not pass on), writes wrap on the low index bits
    // like a real 4096-word array, so a leaked byte enable would show up.
    assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH * 4)) ?
                           mem_model[bus.mem_addr[13:2]] : 32'hDEAD_BEEF;
    assign bus_rr.mem_rdata = 32'h0;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_byteen[b]) begin
                mem_model[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic lock, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        bus.req0 = req; bus.lock0 = lock; bus.addr0 = addr;
        bus.wdata0 = wdata; bus.byteen0 = be;
    endtask

    task automatic drive1(input logic req, input logic lock, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        bus.req1 = req; bus.lock1 = lock; bus.addr1 = addr;
        bus.wdata1 = wdata; bus.byteen1 = be;
    endtask

    task automatic idle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus_rr.req0 = 1'b0; bus_rr.lock0 = 1'b0; bus_rr.addr0 = 32'h0;
        bus_rr.wdata0 = 32'h0; bus_rr.byteen0 = 4'h0;
        bus_rr.req1 = 1'b0; bus_rr.lock1 = 1'b0; bus_rr.addr1 = 32'h4;
        bus_rr.wdata1 = 32'h0; bus_rr.byteen1 = 4'h0;

        // ---- Reset state, with a request present during reset ----
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #1;
        check("rst_gnt0",       bus.gnt0,       1'b0);
        check("rst_gnt1",       bus.gnt1,       1'b0);
        check("rst_rvalid0",    bus.rvalid0,    1'b0);
        check("rst_rdata0",     bus.rdata0,     32'h0);
        check("rst_err0",       bus.err0,       1'b0);
        check("rst_mem_byteen", bus.mem_byteen, 4'h0);
        check("rst_mem_addr",   bus.mem_addr,   32'h0);
        check("rst_mem_wdata",  bus.mem_wdata,  32'h0);
        idle();
        @(negedge clk);
        reset = 1'b0;

        // ---- Requester 0: half-word write then read ----
        drive0(1'b1, 1'b0, 32'h10, 32'hAABB_CCDD, 4'b0011);
        #1;
        check("wr_gnt0",       bus.gnt0,       1'b1);
        check("wr_gnt1",       bus.gnt1,       1'b0);
        check("wr_mem_byteen", bus.mem_byteen, 4'b0011);
        check("wr_mem_addr",   bus.mem_addr,   32'h10);
        check("wr_mem_wdata",  bus.mem_wdata,  32'hAABB_CCDD);
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h12, 32'h0, 4'h0);
        #1;
        check("wr_mem_word4",  mem_model[4],   32'h0000_CCDD);
        check("wr_no_rvalid0", bus.rvalid0,    1'b0);
        check("rd_gnt0",       bus.gnt0,       1'b1);
        check("rd_mem_addr",   bus.mem_addr,   32'h10);
        @(negedge clk);
        idle();
        #1;
        check("rd_rvalid0",    bus.rvalid0,    1'b1);
        check("rd_rdata0",     bus.rdata0,     32'h0000_CCDD);
        check("rd_err0",       bus.err0,       1'b0);
        @(negedge clk);
        #1;
        check("rd_rvalid0_end",  bus.rvalid0,    1'b0);
        check("rd_rdata0_hold",  bus.rdata0,     32'h0000_CCDD);
        check("idle_mem_addr",   bus.mem_addr,   32'h10);
        check("idle_mem_byteen", bus.mem_byteen, 4'h0);
        check("idle_gnt0",       bus.gnt0,       1'b0);

        // ---- Requester 1: full-word write then read of word 9 ----
        drive1(1'b1, 1'b0, 32'h24, 32'h1234_5678, 4'hF);
        #1;
        check("r1_wr_gnt1", bus.gnt1, 1'b1);
        @(negedge clk);
        drive1(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
        #1;
        check("r1_rd_gnt1", bus.gnt1, 1'b1);
        @(negedge clk);
        idle();
        #1;
        check("r1_rvalid1", bus.rvalid1, 1'b1);
        check("r1_rdata1",  bus.rdata1,  32'h1234_5678);
        @(negedge clk);

        // ---- Contention, fixed priority: 8 x gnt0, then forced gnt1 ----
        drive0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        drive1(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("cont_gnt0[%0d]", i), bus.gnt0, (i != 8));
            check($sformatf("cont_gnt1[%0d]", i), bus.gnt1, (i == 8));
            if (i == 8) check("cont_mem_addr", bus.mem_addr, 32'h24);
            if (i == 9) begin
                check("cont_rvalid1", bus.rvalid1, 1'b1);
                check("cont_rdata1",  bus.rdata1,  32'h1234_5678);
            end
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        // ---- Locked burst by requester 0 against a waiting requester 1 ----
        drive0(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        drive1(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("lock_gnt0[%0d]", i), bus.gnt0, (i != 4));
            check($sformatf("lock_gnt1[%0d]", i), bus.gnt1, (i == 4));
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        // ---- Round-robin instance: alternation starting with requester 0 ----
        bus_rr.req0 = 1'b1;
        bus_rr.req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr_gnt0[%0d]", i), bus_rr.gnt0, (i % 2 == 0));
            check($sformatf("rr_gnt1[%0d]", i), bus_rr.gnt1, (i % 2 == 1));
            @(negedge clk);
        end
        bus_rr.req0 = 1'b0;
        bus_rr.req1 = 1'b0;

        // ---- Out-of-range read by requester 1 (word 4096) ----
        drive1(1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
        #1;
        check("oor_rd_gnt1",     bus.gnt1,       1'b1);
        check("oor_rd_byteen",   bus.mem_byteen, 4'h0);
        check("oor_rd_mem_addr", bus.mem_addr,   32'h4000);
        @(negedge clk);
        idle();
        #1;
        check("oor_rd_rvalid1", bus.rvalid1, 1'b1);
        check("oor_rd_err1",    bus.err1,    1'b1);
        check("oor_rd_rdata1",  bus.rdata1,  32'h0);
        @(negedge clk);
        #1;
        check("oor_rd_err1_end", bus.err1, 1'b0);

        // ---- Out-of-range write by requester 1 ----
        drive1(1'b1, 1'b0, 32'h4000, 32'hFFFF_FFFF, 4'hF);
        #1;
        check("oor_wr_gnt1",   bus.gnt1,       1'b1);
        check("oor_wr_byteen", bus.mem_byteen, 4'h0);
        @(negedge clk);
        idle();
        #1;
        check("oor_wr_err1",    bus.err1,     1'b1);
        check("oor_wr_rvalid1", bus.rvalid1,  1'b0);
        check("oor_wr_word0",   mem_model[0], 32'h0);
        @(negedge clk);

        // ---- Reset asserted while a read by requester 0 is in flight ----
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #1;
        check("mid_gnt0", bus.gnt0, 1'b1);
        @(negedge clk);
        #1;
        check("mid_rdata0_pre", bus.rdata0, 32'h0000_CCDD);
        check("mid_gnt0_again", bus.gnt0,   1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_gnt0",     bus.gnt0,     1'b0);
        check("mid_rst_rdata0",   bus.rdata0,   32'h0);
        check("mid_rst_rvalid0",  bus.rvalid0,  1'b0);
        check("mid_rst_mem_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        #1;
        check("mid_rst_rvalid0_after", bus.rvalid0, 1'b0);
        check("mid_rst_rdata0_after",  bus.rdata0,  32'h0);
        idle();
        reset = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed no end of test, expected finish before 50000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
- Shares the single-port data memory (word-addressed, 4096 words, combinational read, byte-enabled synchronous write) between two requesters.
- Requester 0 is the CPU's M-stage data port. Requester 1 is a secondary master, such as the DMA/loader or debug port.
- Decides the grant every cycle and steers the granted requester's address, write data and byte enables to memory.
- Returns registered read data with a per-requester valid pulse, supports short locked bursts and prevents starvation of requester 1.

Parameters:
- DEPTH, 4096: memory depth in 32-bit words; word index = addr>>2.
- MAX_WAIT, 8: cycles requester 1 may wait before a forced grant.
- MAX_LOCK, 4: maximum consecutive locked beats before a forced one-cycle release.
- PRIO_CPU, 1: 1 = fixed priority to requester 0; 0 = round-robin.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1  access request.
- lock0, lock1  in  1  hold grant for next beat (valid with req).
- addr0, addr1  in  32  byte address.
- wdata0, wdata1  in  32  write data.
- byteen0, byteen1  in  4  byte enables; nonzero = write, zero = read.
- gnt0, gnt1  out  1  combinational grant, this cycle.
- rvalid0, rvalid1  out  1  read data valid, one cycle after granted read.
- rdata0, rdata1  out  32  registered read data.
- err0, err1  out  1  one-cycle pulse, out-of-range access, aligned with rvalid timing.
- mem_addr  out  32  word-aligned address (addr & 32'hfffffffc).
- mem_wdata  out  32  write data to memory.
- mem_byteen  out  4  byte enables to memory.
- mem_rdata  in  32  combinational read data for mem_addr.

Behaviour:
- Reset (async, immediate):
  - gnt0/gnt1/rvalid*/err* = 0, rdata* = 0, mem_byteen = 0, mem_addr = 0, mem_wdata = 0.
  - wait_cnt = 0, lock_cnt = 0, lock_owner = none, last_grant = 1, so requester 0 wins the first round-robin tie.
- Grant decision (combinational from req* and registered state), in priority order:
  1. lock_owner = k, req_k = 1 and lock_cnt < MAX_LOCK: grant k.
  2. Exactly one req: grant it.
  3. Both req and wait_cnt == MAX_WAIT: grant 1.
  4. Both req and PRIO_CPU = 1: grant 0.
  5. Both req and PRIO_CPU = 0: grant the requester that is not last_grant.
  6. No req: no grant; mem_byteen = 0; mem_addr/mem_wdata hold previous values.
- At most one gnt high per cycle.
- Memory steering: mem_* driven from the granted requester.
- Out-of-range access (addr>>2 >= DEPTH):
  - mem_byteen forced to 0.
  - Captured read data is 0 and err_k pulses next cycle.
  - For reads, rvalid_k also pulses.
- Write: committed by memory at the posedge of the granted cycle. No rvalid is generated.
- Read latency: with gnt_k in cycle N, rdata_k <= mem_rdata at end of N, and rvalid_k = 1 in cycle N+1 only.
- rdata_k holds its value until the next read by k.
- State updates at posedge:
  - last_grant <= granted index, if any.
  - wait_cnt: +1 (saturating at MAX_WAIT) when req1 && !gnt1. Cleared when gnt1 or !req1.
  - lock_owner <= k when gnt_k && lock_k, else none.
  - lock_cnt: +1 while the same owner is re-granted under lock. Reset to 1 on a new lock start, 0 when released.
  - lock_cnt == MAX_LOCK: the lock is ignored for one arbitration, then normal rules apply. The other requester wins if requesting.
- A requester dropping req mid-lock releases the lock immediately.
- A requester must hold req/addr/wdata/byteen stable until it sees gnt. Ungranted requests are not queued internally.
- Simultaneous events:
  - A forced starvation grant and an active lock by 0 with lock_cnt < MAX_LOCK: the lock wins.
  - Starvation is re-evaluated after the lock releases.

Test Plan:
- Reset mid-read: reset asserted while rvalid0 is pending. rvalid0 stays 0, rdata0 = 0, and gnt* = 0 immediately, without waiting for a clock edge.
- Single write then read by requester 0:
  - req0, addr0 = 0x10, byteen0 = 4'b0011, wdata0 = 0xAABBCCDD → gnt0 = 1, mem_byteen = 0011, memory word 4 low half = 0xCCDD.
  - Then a read at 0x12 → mem_addr = 0x10, rvalid0 = 1 one cycle later, rdata0 = 0x0000CCDD.
- Contention, PRIO_CPU = 1, both requesting continuously, MAX_WAIT = 8: gnt0 for 8 cycles, gnt1 in the 9th cycle, wait_cnt then clears.
- Round-robin, PRIO_CPU = 0, both requesting 6 cycles: grants alternate 0, 1, 0, 1, 0, 1.
- Lock burst: req0 + lock0 held 6 cycles, req1 held, MAX_LOCK = 4 → gnt0 for 4 cycles, then gnt1 for 1 cycle, then gnt0 resumes.
- Out-of-range: req1 read, addr1 = 0x4000 (word 4096) → mem_byteen = 0, next cycle rvalid1 = 1, err1 = 1, rdata1 = 0. The same address as a write → err1 pulse and memory unchanged.
